// File: rtl/pedal_debounce.sv
// pedal_debounce: synchronise, normalise and debounce the foot-pedal switch; press/release strobes and press counter.
// Optional hold-duration timer enabled by defining PEDAL_HOLD_TIMER_EN.
module pedal_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pedal_raw,
  output logic        pedal_clean,
  output logic        press_pulse,
  output logic        release_pulse,
  output logic [15:0] press_count,
  output logic [23:0] hold_last,
  output logic        hold_valid
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic r_s1, r_s2, r_clean, r_press_pulse, r_release_pulse;
  logic [15:0] r_press_count;
  logic w_n, w_done, w_press, w_release;
  assign w_n = (ACTIVE_LOW != 0) ? ~pedal_raw : pedal_raw;
  assign w_done = r_cnt == LAST;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    w_press = 1'b0;
    w_release = 1'b0;
    case (r_state)
      IDLE: if (r_s2) begin
        w_state_nxt = PRESS_WAIT;
        w_cnt_nxt = '0;
      end
      PRESS_WAIT: if (!r_s2) begin
        w_state_nxt = IDLE;
        w_cnt_nxt = '0;
      end else if (w_done) begin
        w_state_nxt = PRESSED;
        w_press = 1'b1;
      end else w_cnt_nxt = r_cnt + CNT_W'(1);
      PRESSED: if (!r_s2) begin
        w_state_nxt = RELEASE_WAIT;
        w_cnt_nxt = '0;
      end
      RELEASE_WAIT: if (r_s2) begin
        w_state_nxt = PRESSED;
        w_cnt_nxt = '0;
      end else if (w_done) begin
        w_state_nxt = IDLE;
        w_release = 1'b1;
      end else w_cnt_nxt = r_cnt + CNT_W'(1);
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_state <= IDLE;
      r_cnt <= '0;
      r_clean <= 1'b0;
      r_press_pulse <= 1'b0;
      r_release_pulse <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_s1 <= w_n;
      r_s2 <= r_s1;
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_press_pulse <= w_press;
      r_release_pulse <= w_release;
      r_clean <= w_press ? 1'b1 : w_release ? 1'b0 : r_clean;
      if (w_press) r_press_count <= r_press_count + 16'd1;
    end
  assign pedal_clean = r_clean;
  assign press_pulse = r_press_pulse;
  assign release_pulse = r_release_pulse;
  assign press_count = r_press_count;
`ifdef PEDAL_HOLD_TIMER_EN
  logic [23:0] r_hold, r_hold_last;
  logic r_hold_valid;
  // counts through release bounces; captured before the release-edge increment
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_hold <= '0;
      r_hold_last <= '0;
      r_hold_valid <= 1'b0;
    end else begin
      r_hold_valid <= w_release;
      if (w_press) r_hold <= '0;
      else if ((r_state == PRESSED || r_state == RELEASE_WAIT) && r_hold != '1) r_hold <= r_hold + 24'd1;
      if (w_release) r_hold_last <= r_hold;
    end
  assign hold_last = r_hold_last;
  assign hold_valid = r_hold_valid;
`else
  assign hold_last = '0;
  assign hold_valid = 1'b0;
`endif
endmodule

// File: tb/tb_pedal_debounce.sv
// tb_pedal_debounce: directed checks of debounce latency, glitch rejection, reset, wrap and hold timer.
module tb_pedal_debounce;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pedal_raw = 1'b1;
  logic pedal_clean, press_pulse, release_pulse, hold_valid;
  logic [15:0] press_count;
  logic [23:0] hold_last;
  int checks = 0;
  int failures = 0;
  int both_high = 0;
`ifdef PEDAL_HOLD_TIMER_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif
  pedal_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(16), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset_n(reset_n), .pedal_raw(pedal_raw),
    .pedal_clean(pedal_clean), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .press_count(press_count), .hold_last(hold_last), .hold_valid(hold_valid)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (press_pulse && release_pulse) both_high++;
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_clean"}, pedal_clean, 0);
    chk({tag, "_press"}, press_pulse, 0);
    chk({tag, "_release"}, release_pulse, 0);
    chk({tag, "_count"}, press_count, 0);
    chk({tag, "_hold_last"}, hold_last, 0);
    chk({tag, "_hold_valid"}, hold_valid, 0);
  endtask
  initial begin
    tick(3);
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    tick(3);
    // bounces of 3 pressed samples never qualify
    for (int k = 0; k < 5; k++) begin
      pedal_raw = 1'b0;
      for (int e = 0; e < 3; e++) begin
        tick(1);
        chk("bounce_clean", pedal_clean, 0);
        chk("bounce_press", press_pulse, 0);
      end
      pedal_raw = 1'b1;
      tick(1);
      chk("bounce_press_hi", press_pulse, 0);
    end
    tick(10);
    chk("bounce_clean_end", pedal_clean, 0);
    chk("bounce_count", press_count, 0);
    // stable press: accepted on edge 7
    pedal_raw = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      chk("press_clean", pedal_clean, (e >= 7) ? 1 : 0);
      chk("press_pulse", press_pulse, (e == 7) ? 1 : 0);
    end
    chk("press_count1", press_count, 1);
    // 2-cycle release glitch is rejected
    pedal_raw = 1'b1;
    tick(2);
    pedal_raw = 1'b0;
    for (int e = 0; e < 10; e++) begin
      chk("glitch_release", release_pulse, 0);
      chk("glitch_clean", pedal_clean, 1);
      tick(1);
    end
    pedal_raw = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      chk("release_pulse", release_pulse, (e == 7) ? 1 : 0);
      chk("release_clean", pedal_clean, (e < 7) ? 1 : 0);
      chk("release_hold_valid", hold_valid, (HOLD_EN && e == 7) ? 1 : 0);
    end
    // hold 100 cycles after clean rises, then release
    tick(4);
    pedal_raw = 1'b0;
    tick(7);
    chk("hold_rise", pedal_clean, 1);
    chk("hold_rise_pulse", press_pulse, 1);
    chk("press_count2", press_count, 2);
    tick(99);
    pedal_raw = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      chk("hold_valid", hold_valid, (HOLD_EN && e == 7) ? 1 : 0);
      chk("hold_rel_pulse", release_pulse, (e == 7) ? 1 : 0);
    end
    chk("hold_last", hold_last, HOLD_EN ? 105 : 0);
    tick(3);
    // reset while in PRESS_WAIT
    pedal_raw = 1'b0;
    tick(4);
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("rst_pw");
    tick(2);
    reset_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      chk("rst_pw_press", press_pulse, (e == 7) ? 1 : 0);
    end
    chk("rst_pw_count", press_count, 1);
    // reset while PRESSED, pedal still held
    tick(2);
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("rst_pr");
    tick(2);
    reset_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      chk("rst_pr_press", press_pulse, (e == 7) ? 1 : 0);
      chk("rst_pr_clean", pedal_clean, (e == 7) ? 1 : 0);
    end
    // press counter wrap
    pedal_raw = 1'b1;
    tick(10);
    force dut.r_press_count = 16'hFFFF;
    tick(1);
    release dut.r_press_count;
    chk("preload", press_count, 16'hFFFF);
    pedal_raw = 1'b0;
    tick(7);
    chk("wrap_pulse", press_pulse, 1);
    chk("wrap_count", press_count, 0);
    chk("strobes_exclusive", both_high, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
